// File: rtl/ring_tuning_pkg.sv
// Shared definitions for the ring-resonator thermal tuning controller:
// FSM state encoding, tracking sub-phases and width helpers.
package ring_tuning_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SET    = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;
    localparam logic [2:0] ST_TRACK  = 3'd6;

    // Phases of one tracking measurement (probe setup, settle, sample).
    localparam logic [1:0] TRK_SETUP  = 2'd0;
    localparam logic [1:0] TRK_SETTLE = 2'd1;
    localparam logic [1:0] TRK_SAMPLE = 2'd2;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Sweep arithmetic runs one bit wider than the code to catch wrap.
    function automatic int sweep_w(input int code_w);
        return code_w + 1;
    endfunction

    function automatic int settle_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ring_tuning_ctrl_pdm.sv
// Pulse-density modulator for one heater: code k gives exactly k ones
// per 2^CODE_W cycles; en gates the output without touching the accumulator.
module pdm_modulator #(
    parameter int CODE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    output logic              pulse
);

    logic [CODE_W:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else     acc <= {1'b0, acc[CODE_W-1:0]} + {1'b0, code};
    end

    assign pulse = acc[CODE_W] & en;

endmodule

// File: rtl/ring_tuning_ctrl.sv
// Multi-channel ring heater controller: sweep-and-lock calibration per channel.
// Define RING_TUNING_TRACK_EN to add round-robin +/-1 tracking after lock.
module ring_tuning_ctrl
    import ring_tuning_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int CODE_W        = 8,
    parameter int MON_W         = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int STEP          = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cal_start,
    input  logic                       mon_valid,
    input  logic [MON_W-1:0]           mon_power,
    output logic [ch_idx_w(NUM_CH)-1:0] mon_ch,
    output logic [NUM_CH-1:0]          heater_out,
    output logic [NUM_CH*CODE_W-1:0]   heater_code,
    output logic [NUM_CH-1:0]          locked,
    output logic                       busy,
    output logic                       done
);

    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam int SW   = settle_w(SETTLE_CYCLES);
    localparam int PW   = sweep_w(CODE_W);
    localparam logic [PW-1:0]     CODE_MAX = {1'b0, {CODE_W{1'b1}}};
    localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

    logic [STATE_W-1:0] state;
    logic [CH_W-1:0]    ch;
    logic               first;
    logic [MON_W-1:0]   best_pwr;
    logic [CODE_W-1:0]  best_code;
    logic [SW-1:0]      settle_cnt;
    logic [NUM_CH-1:0]  locked_q;
    logic [CODE_W-1:0]  code_q [NUM_CH];

    logic [PW-1:0] next_pt;
    logic          last_pt;
    logic          better;

    assign next_pt = {1'b0, code_q[ch]} + PW'(STEP);
    assign last_pt = next_pt > CODE_MAX;
    assign better  = mon_power > best_pwr;

`ifdef RING_TUNING_TRACK_EN
    logic [1:0]        trk_sub;
    logic [1:0]        trk_step;
    logic [CODE_W-1:0] trk_base;
    logic [CODE_W-1:0] trk_plus;
    logic [CODE_W-1:0] trk_minus;

    assign trk_plus  = (trk_base == {CODE_W{1'b1}}) ? trk_base : trk_base + 1'b1;
    assign trk_minus = (trk_base == '0) ? trk_base : trk_base - 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ch         <= '0;
            first      <= 1'b0;
            best_pwr   <= '0;
            best_code  <= '0;
            settle_cnt <= '0;
            locked_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) code_q[i] <= '0;
`ifdef RING_TUNING_TRACK_EN
            trk_sub  <= TRK_SETUP;
            trk_step <= '0;
            trk_base <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cal_start) begin
                        ch       <= '0;
                        locked_q <= '0;
                        first    <= 1'b1;
                        state    <= ST_SET;
                    end
                end
                ST_SET: begin
                    if (first) begin
                        code_q[ch] <= '0;
                        best_pwr   <= '0;
                        best_code  <= '0;
                        first      <= 1'b0;
                    end else begin
                        code_q[ch] <= next_pt[CODE_W-1:0];
                    end
                    settle_cnt <= SETTLE_LOAD;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) state <= ST_SAMPLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    // Strict compare: on equal power the earlier (lower) code stays best.
                    if (mon_valid) begin
                        if (better) begin
                            best_pwr  <= mon_power;
                            best_code <= code_q[ch];
                        end
                        state <= last_pt ? ST_COMMIT : ST_SET;
                    end
                end
                ST_COMMIT: begin
                    code_q[ch]   <= best_code;
                    locked_q[ch] <= 1'b1;
                    if (ch == LAST_CH) begin
                        state <= ST_DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        first <= 1'b1;
                        state <= ST_SET;
                    end
                end
                ST_DONE: begin
`ifdef RING_TUNING_TRACK_EN
                    ch       <= '0;
                    trk_sub  <= TRK_SETUP;
                    trk_step <= '0;
                    state    <= ST_TRACK;
`else
                    state <= ST_IDLE;
`endif
                end
`ifdef RING_TUNING_TRACK_EN
                ST_TRACK: begin
                    if (cal_start) begin
                        ch       <= '0;
                        locked_q <= '0;
                        first    <= 1'b1;
                        state    <= ST_SET;
                    end else begin
                        case (trk_sub)
                            TRK_SETUP: begin
                                // Probe order: current code, code+1, code-1 (saturating).
                                case (trk_step)
                                    2'd0:    trk_base   <= code_q[ch];
                                    2'd1:    code_q[ch] <= trk_plus;
                                    default: code_q[ch] <= trk_minus;
                                endcase
                                settle_cnt <= SETTLE_LOAD;
                                trk_sub    <= TRK_SETTLE;
                            end
                            TRK_SETTLE: begin
                                if (settle_cnt == '0) trk_sub <= TRK_SAMPLE;
                                else                  settle_cnt <= settle_cnt - 1'b1;
                            end
                            default: begin
                                if (mon_valid) begin
                                    if (trk_step == 2'd0 || better) begin
                                        best_pwr  <= mon_power;
                                        best_code <= code_q[ch];
                                    end
                                    if (trk_step == 2'd2) begin
                                        code_q[ch] <= better ? code_q[ch] : best_code;
                                        ch         <= (ch == LAST_CH) ? '0 : ch + 1'b1;
                                        trk_step   <= '0;
                                    end else begin
                                        trk_step <= trk_step + 1'b1;
                                    end
                                    trk_sub <= TRK_SETUP;
                                end
                            end
                        endcase
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign heater_code[i*CODE_W +: CODE_W] = code_q[i];

        pdm_modulator #(.CODE_W(CODE_W)) u_pdm (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .code  (code_q[i]),
            .pulse (heater_out[i])
        );
    end

    assign mon_ch = ch;
    assign locked = locked_q;
    assign busy   = (state != ST_IDLE) && (state != ST_TRACK);
    assign done   = (state == ST_DONE);

endmodule
